pc_fetch_unit: RTL

Instruction-fetch front end of the single-cycle MIPS core. Holds the program counter, drives the word address into the instruction memory, and takes the returned instruction word. Computes the next PC (sequential, branch or jump) and exposes the fetched instruction and PC+4 to decode/control. Adds boot, halt and fault sequencing plus a retired-instruction counter.

---
 rtl/pc_fetch_unit_pkg.sv | 21 ++
 rtl/pc_fetch_unit_next_pc_logic.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the fetch front end: FSM state encoding, reset/depth defaults,
// and the J-type instruction field layout.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam int          DEFAULT_MEM_DEPTH = 256;

   // J-type layout: opcode in [31:26], word target in [25:0].
   typedef struct packed {
      logic [5:0]  opcode;
      logic [25:0] target;
   } j_instr_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for the fetch unit: sequential, branch or jump,
// with stall holding the current PC. Jump takes priority over a taken branch.
module next_pc_logic
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        pc_src,
   input  logic        jump,
   input  logic [31:0] sign_imm,
   input  logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic [31:0] jump_target,
   output logic [31:0] next_pc
);

   j_instr_t    j_fields;
   logic [31:0] branch_target;
   logic        opcode_unused;

   assign j_fields      = j_instr_t'(instr);
   assign opcode_unused = ^j_fields.opcode;

   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + (sign_imm << 2);
   // Jump stays inside the current 256 MB region of the sequential PC.
   assign jump_target   = {pc_plus4[31:28], j_fields.target, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (stall) begin
         next_pc = pc;
      end else if (jump) begin
         next_pc = jump_target;
      end else if (pc_src) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC register, BOOT/RUN/HALT/FAULT sequencing and retired counter.
// Optional FETCH_HALT_DETECT_EN turns a retired self-jump into a terminal HALT.
//
// Handshake: there is no back-pressure handshake; instr_valid is a per-cycle
// qualifier meaning "instr_out executes and retires on this rising edge".
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         pc_src,
   input  logic         jump,
   input  logic [31:0]  sign_imm,
   input  logic [31:0]  instr,
   output logic [31:0]  pc,
   output logic [31:0]  pc_plus4,
   output logic [31:0]  instr_out,
   output logic         instr_valid,
   output logic         halted,
   output logic         fault,
   output logic [31:0]  retired_count,
   output fetch_state_t state_dbg
);

   localparam logic [32:0] PC_LIMIT = 33'(MEM_DEPTH) * 33'd4;

   fetch_state_t state, state_next;
   logic [31:0]  pc_q;
   logic [31:0]  count_q;
   logic [31:0]  next_pc;
   logic [31:0]  jump_target;
   logic         pc_in_range;
   logic         valid_c;
   logic         pc_load;
   logic         fault_q;

   next_pc_logic u_next_pc (
      .pc          (pc_q),
      .stall       (stall),
      .pc_src      (pc_src),
      .jump        (jump),
      .sign_imm    (sign_imm),
      .instr       (instr),
      .pc_plus4    (pc_plus4),
      .jump_target (jump_target),
      .next_pc     (next_pc)
   );

   assign pc_in_range = ({1'b0, pc_q} < PC_LIMIT);

   always_comb begin
      state_next = state;
      valid_c    = 1'b0;
      pc_load    = 1'b0;
      unique case (state)
         ST_BOOT: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            // An out-of-range target was accepted last cycle; it is caught here.
            if (!pc_in_range) begin
               state_next = ST_FAULT;
            end else if (!stall) begin
               valid_c = 1'b1;
               pc_load = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
               if (jump && (jump_target == pc_q)) begin
                  state_next = ST_HALT;
               end
`endif
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_BOOT;
         pc_q    <= RESET_PC;
         count_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_next;
         fault_q <= (state_next == ST_FAULT);
         if (pc_load) begin
            pc_q <= next_pc;
         end
         if (valid_c) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

`ifdef FETCH_HALT_DETECT_EN
   logic halted_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= (state_next == ST_HALT);
      end
   end

   assign halted = halted_q;
`else
   logic jump_target_unused;

   assign jump_target_unused = ^jump_target;
   assign halted             = 1'b0;
`endif

   assign pc            = pc_q;
   assign instr_valid   = valid_c;
   assign instr_out     = valid_c ? instr : 32'd0;
   assign fault         = fault_q;
   assign retired_count = count_q;
   assign state_dbg     = state;

endmodule
